// File: rtl/sat_narrow.sv
// Signed sample narrower with saturation, a 2-entry skid FIFO on the output side,
// and a sticky flag plus saturating counter of clipped samples.
module sat_narrow #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  localparam logic signed [IN_W-1:0] MAX_IN  = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_IN  = IN_W'(-(1 << (OUT_W - 1)));
  localparam logic [OUT_W-1:0]       MAX_OUT = OUT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [OUT_W-1:0]       MIN_OUT = OUT_W'(1 << (OUT_W - 1));
  localparam logic [CNT_W-1:0]       CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic               sat0_q, sat0_d, sat1_q, sat1_d;
  logic               in_ready_q, out_valid_q;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept, xfer;
  logic [OUT_W-1:0]   narrow_data;
  logic               narrow_sat;

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  always_comb begin
    narrow_data = in_data[OUT_W-1:0];
    narrow_sat  = 1'b0;
    if ($signed(in_data) > MAX_IN) begin
      narrow_data = MAX_OUT;
      narrow_sat  = 1'b1;
    end else if ($signed(in_data) < MIN_IN) begin
      narrow_data = MIN_OUT;
      narrow_sat  = 1'b1;
    end
  end

  // Entry 0 is always the oldest and drives the outputs directly.
  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    sat0_d  = sat0_q;
    data1_d = data1_q;
    sat1_d  = sat1_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          data0_d = narrow_data;
          sat0_d  = narrow_sat;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          data0_d = narrow_data;
          sat0_d  = narrow_sat;
        end else if (accept) begin
          state_d = FULL;
          data1_d = narrow_data;
          sat1_d  = narrow_sat;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_d = ONE;
          data0_d = data1_q;
          sat0_d  = sat1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A clear wins over a clipped sample accepted in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (sat_clr) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (accept && narrow_sat) begin
      sticky_d = 1'b1;
      if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q     <= EMPTY;
      data0_q     <= '0;
      sat0_q      <= 1'b0;
      data1_q     <= '0;
      sat1_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      data0_q     <= data0_d;
      sat0_q      <= sat0_d;
      data1_q     <= data1_d;
      sat1_q      <= sat1_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = data0_q;
  assign out_sat    = sat0_q;
  assign sat_sticky = sticky_q;
  assign sat_count  = count_q;

endmodule

// File: tb/tb_sat_narrow.sv
// Directed bench for sat_narrow at default parameters (IN_W=8, OUT_W=2, CNT_W=8).
module tb_sat_narrow;

  logic       Clk = 1'b0;
  logic       Clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_sat;
  logic       out_valid;
  logic       out_ready;
  logic       sat_sticky;
  logic [7:0] sat_count;
  logic       sat_clr;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  sat_narrow dut (
    .Clk        (Clk),
    .Clear      (Clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count),
    .sat_clr    (sat_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] inr_in  [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
  logic [1:0] inr_out [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
  logic [7:0] clp_in  [4] = '{8'h05, 8'h7F, 8'hFD, 8'h80};
  logic [1:0] clp_out [4] = '{2'b01, 2'b01, 2'b10, 2'b10};

  initial begin
    Clear = 1'b1; in_data = 8'h00; in_valid = 1'b1; out_ready = 1'b1; sat_clr = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sticky", sat_sticky, 0);
    chk("rst_count", sat_count, 0);
    Clear = 1'b0; in_valid = 1'b0;
    tick();

    // In-range samples streaming at full rate
    for (int i = 0; i < 4; i++) begin
      in_data = inr_in[i]; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("inr_valid", out_valid, 1);
      chk("inr_data", out_data, inr_out[i]);
      chk("inr_sat", out_sat, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("inr_drained", out_valid, 0);
    chk("inr_count", sat_count, 0);

    // Clipped samples
    for (int i = 0; i < 4; i++) begin
      in_data = clp_in[i]; in_valid = 1'b1;
      tick();
      chk("clp_data", out_data, clp_out[i]);
      chk("clp_sat", out_sat, 1);
      chk("clp_count", sat_count, i + 1);
    end
    chk("clp_sticky", sat_sticky, 1);
    in_valid = 1'b0;
    tick();

    // Backpressure: A, B accepted, C refused while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    tick();
    chk("bp_ready1", in_ready, 1);
    in_data = 8'h00;
    tick();
    chk("bp_ready2", in_ready, 0);
    chk("bp_head", out_data, 2'b01);
    in_data = 8'hFF;
    tick();
    chk("bp_full_hold", in_ready, 0);
    chk("bp_stable", out_data, 2'b01);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_drain1", out_data, 2'b00);
    chk("bp_drain1_v", out_valid, 1);
    tick();
    chk("bp_drain_end", out_valid, 0);
    chk("bp_count", sat_count, 4);

    // Simultaneous accept and transfer, one sample per cycle
    for (int i = 0; i < 10; i++) begin
      in_data = inr_in[i % 4]; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("thr_data", out_data, inr_out[i % 4]);
      chk("thr_valid", out_valid, 1);
      chk("thr_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();

    // Counter saturation and clear priority
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("clr_count", sat_count, 0);
    chk("clr_sticky", sat_sticky, 0);
    in_valid = 1'b1; in_data = 8'h7F;
    for (int i = 0; i < 300; i++) tick();
    chk("cap_count", sat_count, 255);
    chk("cap_sticky", sat_sticky, 1);
    sat_clr = 1'b1; in_data = 8'h80;
    tick();
    chk("clrpri_count", sat_count, 0);
    chk("clrpri_sticky", sat_sticky, 0);
    chk("clrpri_outsat", out_sat, 1);
    chk("clrpri_data", out_data, 2'b10);
    sat_clr = 1'b0;
    tick();
    chk("post_clr_count", sat_count, 1);
    in_valid = 1'b0;
    tick();

    // Reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h85;
    tick(); tick();
    chk("mid_full", in_ready, 0);
    Clear = 1'b1;
    tick();
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_data", out_data, 0);
    chk("mid_out_sat", out_sat, 0);
    chk("mid_sticky", sat_sticky, 0);
    chk("mid_count", sat_count, 0);
    Clear = 1'b0; in_data = 8'hFE; out_ready = 1'b1;
    tick();
    chk("after_rst_v", out_valid, 1);
    chk("after_rst_d", out_data, 2'b10);
    chk("after_rst_sat", out_sat, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
